branch_resolve_unit: RTL and testbench

- Consumer end of the ALU flag interface: takes Zero/Negative/Carry/OverFlow from a compare (subtract) in the execute stage and resolves RISC-V conditional branches, JAL and JALR.
- Produces a registered redirect (target PC) to fetch and drives a squash window that kills younger wrong-path instructions.
- Sits between the execute-stage ALU and fetch/hazard logic. Also keeps saturating branch/taken performance counters.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/branch_cond_eval.sv | 29 ++
 rtl/branch_resolve_unit.sv | 149 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V branch constants and resolve-unit state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

endpackage : riscv_pkg

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from funct3 and subtract flags.
module branch_cond_eval
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       negative,
  input  logic       carry,
  input  logic       overflow,
  output logic       taken_c,
  output logic       illegal_c
);

  // Decode funct3 into a taken decision; 010/011 are reserved encodings.
  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3)
      F3_BEQ:  taken_c = zero;
      F3_BNE:  taken_c = ~zero;
      F3_BLT:  taken_c = negative ^ overflow;
      F3_BGE:  taken_c = ~(negative ^ overflow);
      F3_BLTU: taken_c = ~carry;
      F3_BGEU: taken_c = carry;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule : branch_cond_eval

// File: rtl/branch_resolve_unit.sv
// Resolves branches/JAL/JALR, issues a registered redirect and a squash window.
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_is_branch,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic [2:0]       in_funct3,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_alu_result,
  output logic             out_redirect,
  output logic [31:0]      out_target,
  output logic             out_misaligned,
  output logic             out_illegal,
  output logic             out_squash,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_taken
);

  localparam int unsigned SQ_W = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;

  state_e            state_q, state_d;
  logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
  logic              redirect_q, redirect_d;
  logic [31:0]       target_q, target_d;
  logic              misaligned_q, misaligned_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  branches_q, branches_d;
  logic [CNT_W-1:0]  taken_q, taken_d;

  logic              cond_taken_c;
  logic              cond_illegal_c;
  logic              xfer_c;
  logic              sel_branch_c;
  logic [31:0]       tgt_c;
  logic              unused_alu_lsb;

  assign unused_alu_lsb = in_alu_result[0];

  branch_cond_eval u_cond (
    .funct3    (in_funct3),
    .zero      (in_zero),
    .negative  (in_negative),
    .carry     (in_carry),
    .overflow  (in_overflow),
    .taken_c   (cond_taken_c),
    .illegal_c (cond_illegal_c)
  );

  // Select the transfer kind (jalr > jal > branch) and its target.
  always_comb begin
    xfer_c       = 1'b0;
    sel_branch_c = 1'b0;
    tgt_c        = in_pc + in_imm;
    if (in_is_jalr) begin
      xfer_c = 1'b1;
      tgt_c  = {in_alu_result[31:1], 1'b0};
    end else if (in_is_jal) begin
      xfer_c = 1'b1;
    end else if (in_is_branch) begin
      sel_branch_c = 1'b1;
      xfer_c       = cond_taken_c;
    end
  end

  // Next-state: FSM, registered pulses, target hold and saturating counters.
  always_comb begin
    state_d      = state_q;
    sq_cnt_d     = sq_cnt_q;
    redirect_d   = 1'b0;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    target_d     = target_q;
    branches_d   = branches_q;
    taken_d      = taken_q;
    if (state_q == ST_SQUASH) begin
      sq_cnt_d = sq_cnt_q - SQ_W'(1);
      if (sq_cnt_q == SQ_W'(1)) begin
        state_d = ST_RUN;
      end
    end else if (in_valid) begin
      if (sel_branch_c && cond_illegal_c) begin
        illegal_d = 1'b1;
      end
      if (sel_branch_c && !cond_illegal_c && (branches_q != {CNT_W{1'b1}})) begin
        branches_d = branches_q + CNT_W'(1);
      end
      if (xfer_c) begin
        // Target is also latched on a misaligned transfer to expose the faulting address.
        target_d = tgt_c;
        if (tgt_c[1]) begin
          misaligned_d = 1'b1;
        end else begin
          redirect_d = 1'b1;
          if (taken_q != {CNT_W{1'b1}}) begin
            taken_d = taken_q + CNT_W'(1);
          end
          if (SQUASH_DEPTH > 0) begin
            state_d  = ST_SQUASH;
            sq_cnt_d = SQ_W'(SQUASH_DEPTH);
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      sq_cnt_q     <= '0;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      branches_q   <= '0;
      taken_q      <= '0;
    end else begin
      state_q      <= state_d;
      sq_cnt_q     <= sq_cnt_d;
      redirect_q   <= redirect_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      target_q     <= target_d;
      branches_q   <= branches_d;
      taken_q      <= taken_d;
    end
  end

  assign out_redirect   = redirect_q;
  assign out_target     = target_q;
  assign out_misaligned = misaligned_q;
  assign out_illegal    = illegal_q;
  assign out_squash     = (state_q == ST_SQUASH);
  assign perf_branches  = branches_q;
  assign perf_taken     = taken_q;

endmodule : branch_resolve_unit

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (SQUASH_DEPTH=2, CNT_W=4).
module tb_branch_resolve_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_is_branch, in_is_jal, in_is_jalr;
  logic [2:0]    in_funct3;
  logic          in_zero, in_negative, in_carry, in_overflow;
  logic [31:0]   in_pc, in_imm, in_alu_result;
  logic          out_redirect, out_misaligned, out_illegal, out_squash;
  logic [31:0]   out_target;
  logic [CW-1:0] perf_branches, perf_taken;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.SQUASH_DEPTH(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_branch(in_is_branch),
    .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr), .in_funct3(in_funct3),
    .in_zero(in_zero), .in_negative(in_negative), .in_carry(in_carry),
    .in_overflow(in_overflow), .in_pc(in_pc), .in_imm(in_imm),
    .in_alu_result(in_alu_result), .out_redirect(out_redirect),
    .out_target(out_target), .out_misaligned(out_misaligned),
    .out_illegal(out_illegal), .out_squash(out_squash),
    .perf_branches(perf_branches), .perf_taken(perf_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0;
    in_funct3 = 3'b000; in_zero = 0; in_negative = 0; in_carry = 0; in_overflow = 0;
    in_pc = 32'h0; in_imm = 32'h0; in_alu_result = 32'h0;
  endtask

  task automatic br(input logic [2:0] f3, input logic z, input logic n, input logic c,
                    input logic v, input logic [31:0] pc, input logic [31:0] imm);
    idle();
    in_valid = 1; in_is_branch = 1; in_funct3 = f3;
    in_zero = z; in_negative = n; in_carry = c; in_overflow = v;
    in_pc = pc; in_imm = imm;
  endtask

  // Output snapshot: redirect, target, misaligned, squash, branches, taken.
  task automatic chk_out(input string tag, input logic rd, input logic [31:0] tg, input logic mis,
                         input logic sq, input logic [CW-1:0] nb, input logic [CW-1:0] nt);
    chk({tag, ".redirect"}, 32'(out_redirect), 32'(rd));
    chk({tag, ".target"}, out_target, tg);
    chk({tag, ".misaligned"}, 32'(out_misaligned), 32'(mis));
    chk({tag, ".squash"}, 32'(out_squash), 32'(sq));
    chk({tag, ".branches"}, 32'(perf_branches), 32'(nb));
    chk({tag, ".taken"}, 32'(perf_taken), 32'(nt));
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    chk_out("reset", 0, 32'h0, 0, 0, 0, 0);
    chk("reset.illegal", 32'(out_illegal), 32'h0);
    rst = 0;

    // BEQ taken, 2-cycle squash window
    br(3'b000, 1, 0, 0, 0, 32'h100, 32'h20);
    tick(); chk_out("beq", 1, 32'h120, 0, 1, 1, 1);
    idle();
    tick(); chk_out("beq_sq2", 0, 32'h120, 0, 1, 1, 1);
    tick(); chk_out("beq_run", 0, 32'h120, 0, 0, 1, 1);

    // BLT not less (n=1,v=1), then less (n=1,v=0)
    br(3'b100, 0, 1, 0, 1, 32'h200, 32'h40);
    tick(); chk_out("blt_nt", 0, 32'h120, 0, 0, 2, 1);
    br(3'b100, 0, 1, 0, 0, 32'h200, 32'h40);
    tick(); chk_out("blt_t", 1, 32'h240, 0, 1, 3, 2);
    idle(); tick(); tick();
    chk("blt_run.squash", 32'(out_squash), 32'h0);

    // BLTU / BGEU with wrapping target
    br(3'b110, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h20);
    tick(); chk_out("bltu", 1, 32'h10, 0, 1, 4, 3);
    idle(); tick(); tick();
    br(3'b111, 0, 0, 1, 0, 32'hFFFF_FFF0, 32'h20);
    tick(); chk_out("bgeu", 1, 32'h10, 0, 1, 5, 4);
    idle(); tick(); tick();

    // JALR misaligned, then aligned with all kind bits set (jalr wins)
    idle(); in_valid = 1; in_is_jalr = 1; in_alu_result = 32'h2003;
    tick(); chk_out("jalr_mis", 0, 32'h2002, 1, 0, 5, 4);
    idle(); in_valid = 1; in_is_jalr = 1; in_is_jal = 1; in_is_branch = 1;
    in_funct3 = 3'b000; in_zero = 1; in_pc = 32'h3000; in_imm = 32'h8; in_alu_result = 32'h2001;
    tick(); chk_out("jalr_ok", 1, 32'h2000, 0, 1, 5, 5);

    // Taken branches presented during squash are ignored
    br(3'b000, 1, 0, 0, 0, 32'h300, 32'h4);
    tick(); chk_out("sq_ign1", 0, 32'h2000, 0, 1, 5, 5);
    tick(); chk_out("sq_ign2", 0, 32'h2000, 0, 0, 5, 5);

    // Reset during the first squash cycle
    br(3'b001, 0, 0, 0, 0, 32'h400, 32'h10);
    tick(); chk_out("bne", 1, 32'h410, 0, 1, 6, 6);
    br(3'b000, 1, 0, 0, 0, 32'h500, 32'h4);
    rst = 1;
    tick(); chk_out("rst_mid", 0, 32'h0, 0, 0, 0, 0);
    idle(); rst = 0;
    tick(); chk_out("rst_after", 0, 32'h0, 0, 0, 0, 0);

    // Reserved funct3 010: illegal pulse, no redirect, not counted
    br(3'b010, 1, 0, 1, 0, 32'h600, 32'h8);
    tick(); chk_out("ill", 0, 32'h0, 0, 0, 0, 0);
    chk("ill.pulse", 32'(out_illegal), 32'h1);
    idle();
    tick(); chk("ill.end", 32'(out_illegal), 32'h0);

    // 16 taken JALs saturate the 4-bit perf_taken at 15
    for (int i = 0; i < 16; i++) begin
      idle(); in_valid = 1; in_is_jal = 1; in_pc = 32'h1000; in_imm = 32'h8;
      tick();
      chk("jal.redirect", 32'(out_redirect), 32'h1);
      chk("jal.taken", 32'(perf_taken), (i < 15) ? 32'(i + 1) : 32'd15);
      idle(); tick(); tick();
    end
    chk("jal.target", out_target, 32'h1008);
    chk("jal.branches", 32'(perf_branches), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_resolve_unit
